// File: rtl/serial_adder.sv
// serial_adder: bit-serial, LSB-first unsigned adder.
// One full-adder cell plus a carry flop walks the operands one bit per clock.
// A start/busy/done handshake fronts it; sum/cout are registered and change
// only when an addition completes (or on reset).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_reg,  state_next;
    logic [WIDTH-1:0] a_sh_reg,   a_sh_next;
    logic [WIDTH-1:0] b_sh_reg,   b_sh_next;
    logic [WIDTH-1:0] res_sh_reg, res_sh_next;
    logic             carry_reg,  carry_next;
    logic [CW-1:0]    cnt_reg,    cnt_next;
    logic [WIDTH-1:0] sum_reg,    sum_next;
    logic             cout_reg,   cout_next;
    logic             done_reg,   done_next;

    // The single full-adder cell operating on the current LSBs.
    logic bit_s;
    logic bit_c;
    assign bit_s = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
    assign bit_c = (a_sh_reg[0] & b_sh_reg[0]) | (carry_reg & (a_sh_reg[0] ^ b_sh_reg[0]));

    // State and datapath registers; reset discards any in-flight addition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
            sum_reg    <= '0;
            cout_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_sh_reg   <= a_sh_next;
            b_sh_reg   <= b_sh_next;
            res_sh_reg <= res_sh_next;
            carry_reg  <= carry_next;
            cnt_reg    <= cnt_next;
            sum_reg    <= sum_next;
            cout_reg   <= cout_next;
            done_reg   <= done_next;
        end
    end

    // Next-state and datapath: load on accept, shift one bit per RUN cycle,
    // publish the result on the last bit. done is a one-cycle pulse.
    always_comb begin
        state_next  = state_reg;
        a_sh_next   = a_sh_reg;
        b_sh_next   = b_sh_reg;
        res_sh_next = res_sh_reg;
        carry_next  = carry_reg;
        cnt_next    = cnt_reg;
        sum_next    = sum_reg;
        cout_next   = cout_reg;
        done_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_sh_next   = a;
                    b_sh_next   = b;
                    res_sh_next = '0;
                    carry_next  = 1'b0;
                    cnt_next    = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                a_sh_next   = a_sh_reg >> 1;
                b_sh_next   = b_sh_reg >> 1;
                // Sum bits enter at the MSB so after WIDTH shifts bit 0 is in place.
                res_sh_next = res_sh_reg >> 1;
                res_sh_next[WIDTH-1] = bit_s;
                carry_next  = bit_c;
                cnt_next    = cnt_reg + CW'(1);
                if (cnt_reg == LAST) begin
                    sum_next   = res_sh_next;
                    cout_next  = bit_c;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // busy is a decode of the state flop, so no input reaches an output
    // without passing through a register.
    assign busy = (state_reg == RUN);
    assign done = done_reg;
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: WIDTH=8 and WIDTH=1 instances, scoreboard
// queues filled by the stimulus tasks and drained by done-driven monitors.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // WIDTH=8 instance
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    // WIDTH=1 instance
    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    typedef struct {
        logic [8:0] v;
        int         acc;
    } ent8_t;
    typedef struct {
        logic [1:0] v;
        int         acc;
    } ent1_t;

    ent8_t q8[$];
    ent1_t q1[$];

    int n_checks = 0;
    int n_pass   = 0;
    int acc_cnt8 = 0, done_cnt8 = 0;
    int acc_cnt1 = 0, done_cnt1 = 0;
    logic prev_done8 = 1'b0, prev_done1 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Monitor for the 8-bit instance: every done must match the oldest entry.
    always @(negedge clk) begin
        if (!rst && done8) begin
            done_cnt8++;
            check("done8_one_cycle", 32'(prev_done8), 32'd0);
            if (q8.size() == 0) begin
                n_checks++;
                $display("FAIL done8_unexpected: got done with sum=0x%0h cout=%0b, required no done", sum8, cout8);
            end else begin
                ent8_t e;
                e = q8.pop_front();
                check("result8", 32'({cout8, sum8}), 32'(e.v));
                check("latency8", 32'(cyc - e.acc), 32'd8);
            end
        end
        prev_done8 = done8;
    end

    // Monitor for the 1-bit instance.
    always @(negedge clk) begin
        if (!rst && done1) begin
            done_cnt1++;
            check("done1_one_cycle", 32'(prev_done1), 32'd0);
            if (q1.size() == 0) begin
                n_checks++;
                $display("FAIL done1_unexpected: got done with sum=%0b cout=%0b, required no done", sum1, cout1);
            end else begin
                ent1_t e;
                e = q1.pop_front();
                check("result1", 32'({cout1, sum1}), 32'(e.v));
                check("latency1", 32'(cyc - e.acc), 32'd1);
            end
        end
        prev_done1 = done1;
    end

    // Called at a negedge: waits for busy=0, then presents one start cycle.
    task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic [8:0] ev);
        int n = 0;
        while (busy8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("issue8_timeout", 32'(n), 32'd0);
        a8 = av;
        b8 = bv;
        start8 = 1'b1;
        q8.push_back('{ev, cyc + 1});
        acc_cnt8++;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic issue1(input logic av, input logic bv, input logic [1:0] ev);
        int n = 0;
        while (busy1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("issue1_timeout", 32'(n), 32'd0);
        a1 = av;
        b1 = bv;
        start1 = 1'b1;
        q1.push_back('{ev, cyc + 1});
        acc_cnt1++;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic drain8();
        int n = 0;
        while ((q8.size() != 0 || busy8) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain8", 32'(q8.size()), 32'd0);
    endtask

    task automatic drain1();
        int n = 0;
        while ((q1.size() != 0 || busy1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain1", 32'(q1.size()), 32'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cycles;
        int d0;
        logic [7:0] ra, rb;

        // Reset for two cycles, then check reset values on both instances.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst8_outputs", 32'({busy8, done8, cout8, sum8}), 32'd0);
        check("rst1_outputs", 32'({busy1, done1, cout1, sum1}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 5 + 3, with busy-duration check.
        issue8(8'h05, 8'h03, 9'h008);
        busy_cycles = 0;
        for (int i = 0; i < 20 && busy8; i++) begin
            busy_cycles++;
            @(negedge clk);
        end
        check("busy8_cycles", 32'(busy_cycles), 32'd8);
        check("done8_after_busy", 32'(done8), 32'd1);
        drain8();

        // Carry-out cases.
        issue8(8'hFF, 8'h01, 9'h100);
        issue8(8'hFF, 8'hFF, 9'h1FE);
        drain8();

        // start during RUN is ignored; sum holds the previous result.
        issue8(8'h10, 8'h20, 9'h030);
        repeat (2) @(negedge clk);
        start8 = 1'b1;
        a8 = 8'hAA;
        b8 = 8'h55;
        check("hold_sum_run", 32'({cout8, sum8}), 32'h1FE);
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'h33;
        b8 = 8'h44;
        check("busy_during_run", 32'(busy8), 32'd1);
        check("hold_sum_run2", 32'({cout8, sum8}), 32'h1FE);
        drain8();

        // Reset mid-RUN discards the operation.
        issue8(8'h7F, 8'h01, 9'h080);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        acc_cnt8 -= q8.size();
        q8.delete();
        @(negedge clk);
        check("rst_mid_run", 32'({busy8, done8, cout8, sum8}), 32'd0);
        rst = 1'b0;
        d0 = done_cnt8;
        repeat (12) @(negedge clk);
        check("no_done_after_rst", 32'(done_cnt8), 32'(d0));
        issue8(8'h03, 8'h04, 9'h007);
        drain8();

        // Back-to-back: second start lands in the done cycle.
        issue8(8'h01, 8'h01, 9'h002);
        issue8(8'h80, 8'h80, 9'h100);
        check("b2b_accepted", 32'(busy8), 32'd1);
        drain8();

        // Sweep at WIDTH=8 against a+b.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            issue8(ra, rb, {1'b0, ra} + {1'b0, rb});
        end
        drain8();

        // WIDTH=1: directed then sweep.
        issue1(1'b1, 1'b1, 2'b10);
        issue1(1'b1, 1'b0, 2'b01);
        issue1(1'b0, 1'b0, 2'b00);
        drain1();
        for (int i = 0; i < 1000; i++) begin
            logic x, y;
            x = 1'($urandom_range(0, 1));
            y = 1'($urandom_range(0, 1));
            issue1(x, y, {1'b0, x} + {1'b0, y});
        end
        drain1();

        repeat (3) @(negedge clk);
        check("done8_count", 32'(done_cnt8), 32'(acc_cnt8));
        check("done1_count", 32'(done_cnt1), 32'(acc_cnt1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
